// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback stage of the multicycle RV32I core.
// Contents:
//   - instruction-type codes (4-bit)
//   - writeback-source select codes
//   - writeback FSM state encoding
//   - default datapath width
//   - helper: which instruction types write rd
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] IT_R = 4'd0;
  localparam logic [3:0] IT_I = 4'd1;
  localparam logic [3:0] IT_S = 4'd2;
  localparam logic [3:0] IT_B = 4'd3;
  localparam logic [3:0] IT_U = 4'd4;
  localparam logic [3:0] IT_J = 4'd5;
  localparam logic [3:0] IT_N = 4'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Stores, branches, N-type and any unlisted code never write the register file.
  function automatic logic writes_rd(input logic [3:0] itype);
    return (itype == IT_R) || (itype == IT_I) || (itype == IT_U) || (itype == IT_J);
  endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select (combinational).
// Ports:
//   wb_sel     - source select: ALU, MEM, PC4; code 3 falls back to ALU
//   alu_result - ALU output
//   load_data  - word returned by data memory
//   pc         - instruction PC
//   rf_wdata   - selected writeback value (pc+4 wraps modulo 2^XLEN)
module wb_result_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] rf_wdata
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    rf_wdata = alu_result;
    case (wb_sel)
      WB_MEM:  rf_wdata = load_data;
      WB_PC4:  rf_wdata = pc_plus4;
      default: rf_wdata = alu_result;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: accepts one executed instruction, optionally performs the
// data-memory read for loads, then commits the result to the register file.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   valid_in / ready_out         - upstream handshake (one instruction in flight)
//   instr_type, wb_sel, rd_addr,
//   alu_result, pc               - instruction fields captured on accept
//   mem_re, mem_addr             - data-memory read request / address
//   mem_rdata, mem_rvalid        - data-memory read response
//   rf_we, rf_waddr, rf_wdata    - register-file write port (addr/data 0 when rf_we=0)
//   done                         - one-cycle retire pulse
//   load_err                     - load timeout pulse
// Build option: define WB_LOAD_TIMEOUT_EN to bound the LOAD wait to
// LOAD_TIMEOUT cycles; otherwise LOAD waits forever and load_err is 0.
//
// state  | meaning
// IDLE   | ready for a new instruction
// LOAD   | read request outstanding, waiting for mem_rvalid
// COMMIT | single retire cycle: done, optional register write
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_AW       = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        instr_type,
  input  logic [1:0]        wb_sel,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc,
  output logic              mem_re,
  output logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rvalid,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              done,
  output logic              load_err
);

  if (LOAD_TIMEOUT < 1) begin : g_bad_timeout
    $error("LOAD_TIMEOUT must be at least 1");
  end

  logic [1:0]        state;
  logic [3:0]        type_q;
  logic [1:0]        sel_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   load_q;
  logic [XLEN-1:0]   mux_out;
  logic              in_load;
  logic              in_commit;
  logic              accept;
  logic              timeout;

  // Outputs are forced to their reset values while rst is high so a reset
  // landing on the commit cycle still suppresses the write and retire pulse.
  assign in_load   = (state == ST_LOAD) && !rst;
  assign in_commit = (state == ST_COMMIT) && !rst;
  assign ready_out = (state == ST_IDLE) || rst;
  assign accept    = valid_in && (state == ST_IDLE);

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Down-counter preloaded on accept; reaching zero without rvalid is the
  // LOAD_TIMEOUT-th LOAD cycle.
  assign timeout = in_load && !mem_rvalid && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= CW'(LOAD_TIMEOUT - 1);
    end else if (in_load && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign load_err = timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      type_q <= '0;
      sel_q  <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      pc_q   <= '0;
      load_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            type_q <= instr_type;
            sel_q  <= wb_sel;
            rd_q   <= rd_addr;
            alu_q  <= alu_result;
            pc_q   <= pc;
            // A MEM select on a non-load never reads memory; commit 0, not stale data.
            load_q <= '0;
            state  <= (wb_sel == WB_MEM && instr_type == IT_I) ? ST_LOAD : ST_COMMIT;
          end
        end
        ST_LOAD: begin
          if (mem_rvalid) begin
            load_q <= mem_rdata;
            state  <= ST_COMMIT;
          end else if (timeout) begin
            load_q <= '0;
            state  <= ST_COMMIT;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  wb_result_mux #(.XLEN(XLEN)) u_mux (
    .wb_sel     (sel_q),
    .alu_result (alu_q),
    .load_data  (load_q),
    .pc         (pc_q),
    .rf_wdata   (mux_out)
  );

  assign mem_re   = in_load;
  assign mem_addr = in_load ? alu_q : '0;
  assign done     = in_commit;
  assign rf_we    = in_commit && writes_rd(type_q) && (rd_q != '0);
  assign rf_waddr = rf_we ? rd_q : '0;
  assign rf_wdata = rf_we ? mux_out : '0;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  instr_type;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .REG_AW(5), .LOAD_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .instr_type (instr_type),
    .wb_sel     (wb_sel),
    .rd_addr    (rd_addr),
    .alu_result (alu_result),
    .pc         (pc),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .done       (done),
    .load_err   (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in IDLE; returns one cycle after the accept edge.
  task automatic issue(input logic [3:0] t, input logic [1:0] s, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] p);
    instr_type = t; wb_sel = s; rd_addr = rd; alu_result = alu; pc = p;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic chk_commit(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_we"},    32'(rf_we), 32'(we));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(wa));
    chk({tag, "_wdata"}, rf_wdata, wd);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; instr_type = '0; wb_sel = '0; rd_addr = '0;
    alu_result = '0; pc = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    // R-type ALU writeback
    issue(4'd0, 2'd0, 5'd5, 32'h0000_002A, 32'h0000_1000);
    chk("r_ready_low", 32'(ready_out), 32'd0);
    chk_commit("r", 1'b1, 5'd5, 32'h0000_002A);
    tick();
    chk("r_ready_back", 32'(ready_out), 32'd1);
    chk("r_done_clear", 32'(done), 32'd0);
    chk("r_we_clear", 32'(rf_we), 32'd0);

    // Load, rvalid arrives in the 4th LOAD cycle -> commit 5 cycles after accept
    issue(4'd1, 2'd1, 5'd7, 32'h0000_0100, 32'h0000_2000);
    chk("ld_c1_re", 32'(mem_re), 32'd1);
    chk("ld_c1_addr", mem_addr, 32'h0000_0100);
    tick();
    chk("ld_c2_addr", mem_addr, 32'h0000_0100);
    tick();
    chk("ld_c3_addr", mem_addr, 32'h0000_0100);
    chk("ld_c3_done", 32'(done), 32'd0);
    tick();
    chk("ld_c4_re", 32'(mem_re), 32'd1);
    chk("ld_c4_addr", mem_addr, 32'h0000_0100);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("ld_c5_re", 32'(mem_re), 32'd0);
    chk_commit("ld", 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    chk("ld_ready_back", 32'(ready_out), 32'd1);

    // Load with rvalid in the first LOAD cycle
    issue(4'd1, 2'd1, 5'd9, 32'h0000_0200, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk_commit("ld_fast", 1'b1, 5'd9, 32'h1234_5678);
    tick();

    // J-type PC+4, with and without wrap
    issue(4'd5, 2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC);
    chk_commit("j_wrap", 1'b1, 5'd1, 32'h0000_0000);
    tick();
    issue(4'd5, 2'd2, 5'd1, 32'h0, 32'h0000_0040);
    chk_commit("j_pc4", 1'b1, 5'd1, 32'h0000_0044);
    tick();

    // No-write retirements
    issue(4'd2, 2'd0, 5'd4, 32'h0000_0010, 32'h0);
    chk_commit("s_type", 1'b0, 5'd0, 32'h0);
    tick();
    issue(4'd3, 2'd0, 5'd4, 32'h0000_0010, 32'h0);
    chk_commit("b_type", 1'b0, 5'd0, 32'h0);
    tick();
    issue(4'd0, 2'd0, 5'd0, 32'h0000_0099, 32'h0);
    chk_commit("r_x0", 1'b0, 5'd0, 32'h0);
    tick();
    issue(4'd7, 2'd0, 5'd3, 32'h0000_0099, 32'h0);
    chk_commit("n_type", 1'b0, 5'd0, 32'h0);
    tick();

    // Reserved select falls back to ALU; U-type writes
    issue(4'd4, 2'd3, 5'd12, 32'hABCD_0000, 32'h0000_0500);
    chk_commit("u_sel3", 1'b1, 5'd12, 32'hABCD_0000);
    tick();

    // MEM select on a non-load does not read memory
    issue(4'd0, 2'd1, 5'd6, 32'h0000_0300, 32'h0);
    chk("rmem_no_re", 32'(mem_re), 32'd0);
    chk_commit("rmem", 1'b1, 5'd6, 32'h0);
    tick();

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_rv_done", 32'(done), 32'd0);
    chk("stray_rv_ready", 32'(ready_out), 32'd1);

    // Reset during LOAD wait aborts the load
    issue(4'd1, 2'd1, 5'd8, 32'h0000_0400, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_in_load_re", 32'(mem_re), 32'd0);
    tick();
    rst = 1'b0;
    chk("abort_re", 32'(mem_re), 32'd0);
    chk("abort_ready", 32'(ready_out), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(rf_we), 32'd0);
    tick();
    chk("abort_done2", 32'(done), 32'd0);

    // Load with no response
    issue(4'd1, 2'd1, 5'd3, 32'h0000_0600, 32'h0);
`ifdef WB_LOAD_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      chk("to_early_err", 32'(load_err), 32'd0);
      tick();
    end
    chk("to_err_pulse", 32'(load_err), 32'd1);
    chk("to_re_c16", 32'(mem_re), 32'd1);
    tick();
    chk("to_err_clear", 32'(load_err), 32'd0);
    chk_commit("to_commit", 1'b1, 5'd3, 32'h0);
    tick();
    chk("to_ready_back", 32'(ready_out), 32'd1);
`else
    repeat (24) tick();
    chk("hang_re", 32'(mem_re), 32'd1);
    chk("hang_addr", mem_addr, 32'h0000_0600);
    chk("hang_done", 32'(done), 32'd0);
    chk("hang_err", 32'(load_err), 32'd0);
    chk("hang_ready", 32'(ready_out), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hang_rst_ready", 32'(ready_out), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
